voice_scheduler: RTL and testbench
==================================

Name: voice_scheduler

Overview:
Sits between the song reader and a bank of NUM_VOICES note_player instances, forming the chord front end. Accepts notes over a valid/ready handshake and buffers them in a small FIFO. Dispatches each note to a free voice with round-robin priority, driving a shared note/duration bus and a one-cycle per-voice load strobe. Replaces ad-hoc priority muxing so notes are never dropped when voices are busy.

Parameters:
NUM_VOICES, 3, number of note_player voices scheduled (2..8)
FIFO_DEPTH, 4, pending-note buffer entries (power of two, >=2)
ACK_TIMEOUT, 4, cycles a just-loaded voice stays masked if its done flag never drops

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
note_valid  input  1  song reader presents a note
note_in  input  6  note number
duration_in  input  6  duration in beats
note_ready  output  1  FIFO can accept; transfer when note_valid & note_ready
play_enable  input  1  high = dispatch allowed; low = hold queue, still accept
flush  input  1  synchronous clear of FIFO and dispatch state
voice_done  input  NUM_VOICES  done_with_note from each note_player
load_new_note  output  NUM_VOICES  one-hot, one-cycle load strobe per voice
note_out  output  6  shared note bus to all voices
duration_out  output  6  shared duration bus to all voices
player_available  output  1  at least one voice free and unmasked
fifo_count  output  clog2(FIFO_DEPTH)+1  occupancy

Behaviour:
- Reset (reset=0): FIFO empty, rr pointer=0, busy mask=0, load_new_note=0, note_out=0, duration_out=0, note_ready=1, fifo_count=0, FSM=IDLE.
- FIFO: note_ready = (fifo_count != FIFO_DEPTH), combinational from count. Push stores {note_in,duration_in}. Simultaneous push and pop when full: push refused (ready low); count unchanged only when both occur on a non-full FIFO.
- Voice free: voice_done[i]=1 and mask[i]=0.
- Grant: first free voice at or after rr pointer, wrapping modulo NUM_VOICES. After a grant, rr = granted+1 (wrapping).
- FSM IDLE -> ISSUE when FIFO non-empty, play_enable=1 and any voice free. On transition: pop head, register note_out/duration_out and grant index.
- ISSUE (1 cycle): load_new_note[grant]=1; note_out/duration_out hold popped values; set mask[grant]; go to IDLE.
- Latency: note accepted at cycle t into an empty FIFO with a free voice -> pop at t+1 -> strobe at t+2. Back-to-back dispatch is possible every 2 cycles.
- note_out/duration_out hold their last value outside ISSUE.
- Mask clear: mask[i] clears the first cycle voice_done[i]=0 is sampled, or after ACK_TIMEOUT cycles from the strobe (per-voice counter), whichever comes first. This prevents a voice's stale done flag from causing a double grant.
- All voices busy: the note stays in the FIFO; the song reader back-pressures only once the FIFO is full.
- play_enable=0: no IDLE->ISSUE transition. An ISSUE already entered completes.
- flush=1: FIFO emptied, FSM->IDLE, strobes forced 0, masks and counters cleared; rr pointer kept. A push on the same cycle as flush is discarded.
- player_available = OR over free voices (combinational).
- Asynchronous reset mid-ISSUE aborts the strobe immediately.

Decomposition:
- Shared package/header: note and duration widths (6), FSM state encodings (IDLE, ISSUE), the round-robin find-first function.
- One natural sub-module: note_fifo (parameterised width 12, depth FIFO_DEPTH, count output, synchronous clear).
- Arbiter and FSM stay in voice_scheduler.

Test Plan:
- Reset release, all voice_done=1, push note 6'd20/dur 6'd12 at cycle t -> load_new_note=3'b001 at t+2 with note_out=20, duration_out=12; voice0 drops done next cycle, mask clears.
- Three notes pushed back-to-back, all voices free -> strobes 001, 010, 100 on cycles t+2, t+4, t+6; rr returns to 0.
- All voice_done=0, push 5 notes with FIFO_DEPTH=4 -> fifo_count=4, note_ready=0 on the 5th; raise voice_done[1] -> strobe 010 with the first note, note_ready returns to 1.
- voice_done[2] held at 1 and never drops after grant -> voice 2 not re-granted for 4 cycles, then eligible again; no double strobe within the window.
- play_enable=0 with 2 queued notes and free voices -> no strobe, count stays 2; set play_enable=1 -> dispatch resumes 1 cycle later.
- flush asserted with 3 queued notes and a simultaneous push -> fifo_count=0 next cycle, no strobe. Reset asserted during ISSUE -> load_new_note=0 immediately.

Source files
------------

// File: rtl/voice_scheduler_pkg.sv
// ============================================================================
// Module      : voice_scheduler_pkg
// Description : Shared widths, FSM states and round-robin pick for the
//               voice scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package voice_scheduler_pkg;

    localparam int NOTE_W     = 6;
    localparam int DUR_W      = 6;
    localparam int ENTRY_W    = NOTE_W + DUR_W;
    localparam int MAX_VOICES = 8;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_e;

    // Returns {found, index} of the first set bit at or after ptr, wrapping at n.
    function automatic logic [3:0] rr_pick(
        input logic [MAX_VOICES-1:0] free,
        input logic [2:0]            ptr,
        input int                    n
    );
        logic [3:0] res;
        int         sum;
        res = '0;
        for (int k = MAX_VOICES - 1; k >= 0; k--) begin
            if (k < n) begin
                sum = int'(ptr) + k;
                if (sum >= n) begin
                    sum = sum - n;
                end
                if (free[sum[2:0]]) begin
                    res = {1'b1, sum[2:0]};
                end
            end
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/voice_scheduler_note_fifo.sv
// ============================================================================
// Module      : note_fifo
// Description : Pending-note FIFO with occupancy count and synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module note_fifo
    import voice_scheduler_pkg::*;
#(
    parameter int WIDTH = ENTRY_W,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/voice_scheduler.sv
// ============================================================================
// Module      : voice_scheduler
// Description : Buffers incoming notes and dispatches each to a free voice
//               with round-robin priority and a one-cycle load strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module voice_scheduler
    import voice_scheduler_pkg::*;
#(
    parameter int NUM_VOICES  = 3,
    parameter int FIFO_DEPTH  = 4,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        note_valid,
    input  logic [NOTE_W-1:0]           note_in,
    input  logic [DUR_W-1:0]            duration_in,
    output logic                        note_ready,
    input  logic                        play_enable,
    input  logic                        flush,
    input  logic [NUM_VOICES-1:0]       voice_done,
    output logic [NUM_VOICES-1:0]       load_new_note,
    output logic [NOTE_W-1:0]           note_out,
    output logic [DUR_W-1:0]            duration_out,
    output logic                        player_available,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int         TW   = $clog2(ACK_TIMEOUT + 1);
    localparam logic [2:0] LAST = 3'(NUM_VOICES - 1);

    state_e                  state_q, state_d;
    logic [2:0]              rr_q;
    logic [2:0]              grant_q;
    logic [NOTE_W-1:0]       note_q;
    logic [DUR_W-1:0]        dur_q;
    logic [NUM_VOICES-1:0]   mask_q;
    logic [TW-1:0]           cnt_q [NUM_VOICES];

    logic [NUM_VOICES-1:0]   free_w;
    logic [3:0]              pick_w;
    logic                    start_w;
    logic [ENTRY_W-1:0]      head_w;
    logic                    fifo_empty_w;
    logic                    fifo_full_w;

    assign free_w           = voice_done & ~mask_q;
    assign player_available = |free_w;
    assign pick_w           = rr_pick(8'(free_w), rr_q, NUM_VOICES);
    assign start_w          = (state_q == ST_IDLE) && !fifo_empty_w && play_enable
                              && pick_w[3] && !flush;
    assign note_ready       = ~fifo_full_w;
    assign note_out         = note_q;
    assign duration_out     = dur_q;

    note_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .clear_i (flush),
        .push_i  (note_valid & note_ready),
        .pop_i   (start_w),
        .wdata_i ({note_in, duration_in}),
        .rdata_o (head_w),
        .count_o (fifo_count),
        .full_o  (fifo_full_w),
        .empty_o (fifo_empty_w)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_w) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        load_new_note = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if ((state_q == ST_ISSUE) && !flush && (grant_q == 3'(i))) begin
                load_new_note[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_q    <= '0;
            grant_q <= '0;
            note_q  <= '0;
            dur_q   <= '0;
        end else if (start_w) begin
            grant_q <= pick_w[2:0];
            rr_q    <= (pick_w[2:0] == LAST) ? 3'd0 : pick_w[2:0] + 3'd1;
            note_q  <= head_w[ENTRY_W-1:DUR_W];
            dur_q   <= head_w[DUR_W-1:0];
        end
    end

    // A just-loaded voice stays masked until its done flag drops or the timeout expires.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask_q <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (flush) begin
                    mask_q[i] <= 1'b0;
                    cnt_q[i]  <= '0;
                end else if ((state_q == ST_ISSUE) && (grant_q == 3'(i))) begin
                    mask_q[i] <= 1'b1;
                    cnt_q[i]  <= '0;
                end else if (mask_q[i]) begin
                    if (!voice_done[i] || (cnt_q[i] == TW'(ACK_TIMEOUT - 1))) begin
                        mask_q[i] <= 1'b0;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + 1'b1;
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_voice_scheduler.sv
// ============================================================================
// Module      : tb_voice_scheduler
// Description : Directed and randomized bench for voice_scheduler with a
//               queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_voice_scheduler;

    localparam int NV    = 3;
    localparam int DEPTH = 4;
    localparam int TO    = 4;

    logic       clk;
    logic       reset;
    logic       note_valid;
    logic [5:0] note_in;
    logic [5:0] duration_in;
    logic       note_ready;
    logic       play_enable;
    logic       flush;
    logic [2:0] voice_done;
    logic [2:0] load_new_note;
    logic [5:0] note_out;
    logic [5:0] duration_out;
    logic       player_available;
    logic [2:0] fifo_count;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // reference model state
    logic [11:0] mq[$];
    bit          m_issue;
    int          m_grant;
    int          m_rr;
    logic [5:0]  m_note;
    logic [5:0]  m_dur;
    bit          m_mask [NV];
    int          m_strobe_at [NV];

    // last sampled outputs
    logic [2:0] obs_load;
    logic [5:0] obs_note;
    logic [5:0] obs_dur;
    logic [2:0] obs_count;
    logic       obs_ready;

    voice_scheduler #(
        .NUM_VOICES  (NV),
        .FIFO_DEPTH  (DEPTH),
        .ACK_TIMEOUT (TO)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .note_valid       (note_valid),
        .note_in          (note_in),
        .duration_in      (duration_in),
        .note_ready       (note_ready),
        .play_enable      (play_enable),
        .flush            (flush),
        .voice_done       (voice_done),
        .load_new_note    (load_new_note),
        .note_out         (note_out),
        .duration_out     (duration_out),
        .player_available (player_available),
        .fifo_count       (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        mq.delete();
        m_issue = 0;
        m_grant = 0;
        m_rr    = 0;
        m_note  = '0;
        m_dur   = '0;
        for (int i = 0; i < NV; i++) begin
            m_mask[i]      = 0;
            m_strobe_at[i] = 0;
        end
    endtask

    // One clock cycle: compare against the model, advance the model, move to next negedge.
    task automatic tick();
        logic [2:0] exp_load;
        logic       exp_avail;
        bit         free_now [NV];
        bit         pushed;
        bit         found;
        int         g;
        logic [11:0] head;
        #1;
        if (!reset) model_reset();
        exp_load  = '0;
        exp_avail = 1'b0;
        if (reset && m_issue && !flush) exp_load[m_grant] = 1'b1;
        for (int i = 0; i < NV; i++) begin
            free_now[i] = voice_done[i] && !m_mask[i];
            if (free_now[i]) exp_avail = 1'b1;
        end
        obs_load  = load_new_note;
        obs_note  = note_out;
        obs_dur   = duration_out;
        obs_count = fifo_count;
        obs_ready = note_ready;

        checks++;
        if (fifo_count !== 3'(mq.size())) begin
            errors++;
            $display("FAIL model_count cyc=%0d got=%0d exp=%0d", cyc, fifo_count, mq.size());
        end
        checks++;
        if (note_ready !== (mq.size() != DEPTH)) begin
            errors++;
            $display("FAIL model_ready cyc=%0d got=%b exp=%b", cyc, note_ready, mq.size() != DEPTH);
        end
        checks++;
        if (load_new_note !== exp_load) begin
            errors++;
            $display("FAIL model_load cyc=%0d got=%b exp=%b", cyc, load_new_note, exp_load);
        end
        checks++;
        if (note_out !== m_note || duration_out !== m_dur) begin
            errors++;
            $display("FAIL model_bus cyc=%0d got=%0d/%0d exp=%0d/%0d",
                     cyc, note_out, duration_out, m_note, m_dur);
        end
        checks++;
        if (player_available !== exp_avail) begin
            errors++;
            $display("FAIL model_avail cyc=%0d got=%b exp=%b", cyc, player_available, exp_avail);
        end

        if (reset) begin
            if (flush) begin
                mq.delete();
                m_issue = 0;
                for (int i = 0; i < NV; i++) m_mask[i] = 0;
            end else begin
                pushed = note_valid && (mq.size() < DEPTH);
                for (int i = 0; i < NV; i++) begin
                    if (m_mask[i] && (!voice_done[i] || (cyc - m_strobe_at[i] >= TO)))
                        m_mask[i] = 0;
                end
                if (m_issue) begin
                    m_mask[m_grant]      = 1;
                    m_strobe_at[m_grant] = cyc;
                    m_issue              = 0;
                end else if (mq.size() > 0 && play_enable) begin
                    found = 0;
                    g     = 0;
                    for (int k = 0; k < NV; k++) begin
                        if (!found && free_now[(m_rr + k) % NV]) begin
                            found = 1;
                            g     = (m_rr + k) % NV;
                        end
                    end
                    if (found) begin
                        head    = mq.pop_front();
                        m_note  = head[11:6];
                        m_dur   = head[5:0];
                        m_grant = g;
                        m_rr    = (g + 1) % NV;
                        m_issue = 1;
                    end
                end
                if (pushed) mq.push_back({note_in, duration_in});
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset       = 1'b0;
        note_valid  = 1'b0;
        note_in     = '0;
        duration_in = '0;
        play_enable = 1'b1;
        flush       = 1'b0;
        voice_done  = 3'b111;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (obs_load !== 3'b000 || obs_note !== 6'd0 || obs_dur !== 6'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%b/%0d/%0d exp=000/0/0", obs_load, obs_note, obs_dur);
        end
        checks++;
        if (obs_ready !== 1'b1 || obs_count !== 3'd0) begin
            errors++;
            $display("FAIL reset_fifo got=%b/%0d exp=1/0", obs_ready, obs_count);
        end
    endtask

    task automatic test_latency();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            note_valid  = (c == 0);
            note_in     = 6'd20;
            duration_in = 6'd12;
            voice_done  = (c >= 3) ? 3'b110 : 3'b111;
            tick();
            checks++;
            if (obs_load !== ((c == 2) ? 3'b001 : 3'b000)) begin
                errors++;
                $display("FAIL latency_strobe c=%0d got=%b exp=%b", c, obs_load,
                         (c == 2) ? 3'b001 : 3'b000);
            end
            if (c == 2) begin
                checks++;
                if (obs_note !== 6'd20 || obs_dur !== 6'd12) begin
                    errors++;
                    $display("FAIL latency_bus got=%0d/%0d exp=20/12", obs_note, obs_dur);
                end
            end
        end
        voice_done = 3'b111;
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            note_valid  = (c < 3) || (c == 8);
            note_in     = 6'(30 + c);
            duration_in = 6'(c + 1);
            tick();
            exp = (c == 2) ? 3'b001 : (c == 4) ? 3'b010 : (c == 6) ? 3'b100 :
                  (c == 10) ? 3'b001 : 3'b000;
            checks++;
            if (obs_load !== exp) begin
                errors++;
                $display("FAIL b2b_strobe c=%0d got=%b exp=%b", c, obs_load, exp);
            end
        end
    endtask

    task automatic test_full();
        int idx;
        do_reset();
        for (int c = 0; c < 9; c++) begin
            idx         = (c < 4) ? c : 4;
            note_valid  = (c <= 6);
            note_in     = 6'(idx + 1);
            duration_in = 6'(idx + 10);
            voice_done  = (c >= 5) ? 3'b010 : 3'b000;
            tick();
            if (c == 4) begin
                checks++;
                if (obs_ready !== 1'b0 || obs_count !== 3'd4) begin
                    errors++;
                    $display("FAIL full_backpressure got=%b/%0d exp=0/4", obs_ready, obs_count);
                end
            end
            if (c == 6) begin
                checks++;
                if (obs_load !== 3'b010 || obs_note !== 6'd1 || obs_dur !== 6'd10
                    || obs_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL full_drain got=%b/%0d/%0d/%b exp=010/1/10/1",
                             obs_load, obs_note, obs_dur, obs_ready);
                end
            end
        end
    endtask

    task automatic test_timeout();
        logic [2:0] exp;
        do_reset();
        voice_done = 3'b100;
        for (int c = 0; c < 12; c++) begin
            note_valid  = (c < 2);
            note_in     = 6'(40 + c);
            duration_in = 6'(50 + c);
            tick();
            exp = (c == 2 || c == 8) ? 3'b100 : 3'b000;
            checks++;
            if (obs_load !== exp) begin
                errors++;
                $display("FAIL timeout_strobe c=%0d got=%b exp=%b", c, obs_load, exp);
            end
        end
        voice_done = 3'b111;
    endtask

    task automatic test_play_enable();
        do_reset();
        play_enable = 1'b0;
        for (int c = 0; c < 8; c++) begin
            note_valid  = (c < 2);
            note_in     = 6'(c + 3);
            duration_in = 6'(c + 7);
            play_enable = (c >= 5);
            tick();
            if (c == 4) begin
                checks++;
                if (obs_count !== 3'd2 || obs_load !== 3'b000) begin
                    errors++;
                    $display("FAIL play_hold got=%0d/%b exp=2/000", obs_count, obs_load);
                end
            end
            if (c == 6) begin
                checks++;
                if (obs_load !== 3'b001 || obs_note !== 6'd3) begin
                    errors++;
                    $display("FAIL play_resume got=%b/%0d exp=001/3", obs_load, obs_note);
                end
            end
        end
        play_enable = 1'b1;
    endtask

    task automatic test_flush();
        do_reset();
        voice_done = 3'b000;
        for (int c = 0; c < 6; c++) begin
            note_valid  = (c <= 3);
            note_in     = 6'(c + 11);
            duration_in = 6'(c + 21);
            flush       = (c == 3);
            tick();
            if (c == 4) begin
                checks++;
                if (obs_count !== 3'd0 || obs_load !== 3'b000 || obs_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL flush_clear got=%0d/%b/%b exp=0/000/1",
                             obs_count, obs_load, obs_ready);
                end
            end
        end
        voice_done = 3'b111;
    endtask

    task automatic test_reset_issue();
        do_reset();
        note_valid  = 1'b1;
        note_in     = 6'd9;
        duration_in = 6'd5;
        tick();
        note_valid = 1'b0;
        tick();
        #1;
        checks++;
        if (load_new_note !== 3'b001) begin
            errors++;
            $display("FAIL rst_issue_pre got=%b exp=001", load_new_note);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (load_new_note !== 3'b000) begin
            errors++;
            $display("FAIL rst_issue_abort got=%b exp=000", load_new_note);
        end
        tick();
        reset = 1'b1;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            note_valid  = ($urandom_range(0, 1) == 1);
            note_in     = 6'($urandom_range(0, 63));
            duration_in = 6'($urandom_range(0, 63));
            play_enable = ($urandom_range(0, 7) != 0);
            flush       = ($urandom_range(0, 31) == 0);
            for (int i = 0; i < NV; i++) begin
                if ($urandom_range(0, 3) == 0) voice_done[i] = ~voice_done[i];
            end
            tick();
        end
        flush       = 1'b0;
        play_enable = 1'b1;
    endtask

    initial begin
        reset       = 1'b0;
        note_valid  = 1'b0;
        note_in     = '0;
        duration_in = '0;
        play_enable = 1'b1;
        flush       = 1'b0;
        voice_done  = 3'b111;
        model_reset();
        @(negedge clk);
        test_reset();
        test_latency();
        test_back_to_back();
        test_full();
        test_timeout();
        test_play_enable();
        test_flush();
        test_reset_issue();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
